// File: rtl/axi_byte_master_addresser.sv
// Empty package; the address mapping module axi_byte_addresser is in rtl/axi_byte_addresser.sv.
package axi_byte_master_addresser_unused_pkg;
endpackage

// File: rtl/axi_byte_pkg.sv
// Shared types and constants for the single-outstanding AXI4-Lite byte master.
package axi_byte_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrAwW,
    StWrB,
    StRdAr,
    StRdR,
    StDone
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int unsigned LANE_BITS = 3;

  function automatic logic resp_is_err(input logic [1:0] resp);
    case (resp)
      AXI_RESP_OKAY:                   return 1'b0;
      AXI_RESP_SLVERR, AXI_RESP_DECERR: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/axi_byte_addresser.sv
// Byte-to-64-bit-bus mapping: aligned address, write strobe, replicated write data, read lane.
module axi_byte_addresser
  import axi_byte_pkg::*;
(
  input  logic [31:0] i_addr,
  input  logic [7:0]  i_wbyte,
  input  logic [63:0] i_rdata,
  output logic [31:0] o_axaddr,
  output logic [7:0]  o_wstrb,
  output logic [63:0] o_wdata,
  output logic [7:0]  o_rbyte
);

  logic [LANE_BITS-1:0] w_lane;

  assign w_lane   = i_addr[LANE_BITS-1:0];
  assign o_axaddr = {i_addr[31:LANE_BITS], {LANE_BITS{1'b0}}};
  assign o_wstrb  = 8'b1 << w_lane;
  assign o_wdata  = {8{i_wbyte}};
  assign o_rbyte  = i_rdata[{w_lane, 3'b000} +: 8];

endmodule

// File: rtl/axi_byte_master.sv
// Single-outstanding AXI4-Lite master doing one byte read/write per request on a 64-bit bus.
// Optional bus-fault timeout enabled by defining AXI_BYTE_MASTER_TIMEOUT_EN.
module axi_byte_master
  import axi_byte_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [63:0] m_axi_wdata,
  output logic [7:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [63:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  state_e      r_state;
  logic        r_req_ready;
  logic [31:0] r_addr;
  logic [7:0]  r_wbyte;
  logic        r_aw_done, r_w_done;
  logic        r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic        r_rsp_valid, r_rsp_error, r_rsp_timeout;
  logic [7:0]  r_rsp_rdata;

  logic [31:0] w_axaddr;
  logic [7:0]  w_wstrb, w_rbyte;
  logic [63:0] w_wdata;
  logic        w_aw_hs, w_w_hs, w_aw_all, w_w_all, w_tmo;

  axi_byte_addresser u_addresser (
    .i_addr   (r_addr),
    .i_wbyte  (r_wbyte),
    .i_rdata  (m_axi_rdata),
    .o_axaddr (w_axaddr),
    .o_wstrb  (w_wstrb),
    .o_wdata  (w_wdata),
    .o_rbyte  (w_rbyte)
  );

  assign w_aw_hs  = r_awvalid & m_axi_awready;
  assign w_w_hs   = r_wvalid & m_axi_wready;
  assign w_aw_all = r_aw_done | w_aw_hs;
  assign w_w_all  = r_w_done | w_w_hs;

`ifdef AXI_BYTE_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  state_e          r_cnt_state;
  logic [CntW-1:0] r_cnt, w_cnt;
  logic            w_waiting;

  // A state differing from last cycle's means the count restarts from zero.
  assign w_waiting = r_state inside {StWrAwW, StWrB, StRdAr, StRdR};
  assign w_cnt     = (r_state != r_cnt_state) ? '0 : r_cnt;
  assign w_tmo     = w_waiting && (w_cnt == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_cnt_state <= StIdle;
    end else begin
      r_cnt_state <= r_state;
      r_cnt       <= w_waiting ? w_cnt + 1'b1 : '0;
    end
  end
`else
  logic w_unused_tmo_cfg;
  assign w_unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign w_tmo            = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= StIdle;
      r_req_ready   <= 1'b0;
      r_addr        <= '0;
      r_wbyte       <= '0;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_error   <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else if (w_tmo) begin
      // Abandon the bus: any late response is deliberately ignored.
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_valid   <= 1'b1;
      r_rsp_rdata   <= '0;
      r_rsp_error   <= 1'b1;
      r_rsp_timeout <= 1'b1;
      r_state       <= StDone;
    end else begin
      case (r_state)
        StIdle: begin
          if (req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_addr      <= req_addr;
            r_wbyte     <= req_wdata;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            if (req_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= StWrAwW;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= StRdAr;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        StWrAwW: begin
          if (w_aw_all && w_w_all) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= StWrB;
          end else begin
            if (w_aw_hs) begin
              r_awvalid <= 1'b0;
              r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
              r_wvalid <= 1'b0;
              r_w_done <= 1'b1;
            end
          end
        end
        StWrB: begin
          if (m_axi_bvalid) begin
            r_bready      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_error   <= resp_is_err(m_axi_bresp);
            r_rsp_timeout <= 1'b0;
            r_state       <= StDone;
          end
        end
        StRdAr: begin
          if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= StRdR;
          end
        end
        StRdR: begin
          if (m_axi_rvalid) begin
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= w_rbyte;
            r_rsp_error   <= resp_is_err(m_axi_rresp);
            r_rsp_timeout <= 1'b0;
            r_state       <= StDone;
          end
        end
        StDone: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_error     = r_rsp_error;
  assign rsp_timeout   = r_rsp_timeout;
  assign m_axi_awaddr  = w_axaddr;
  assign m_axi_araddr  = w_axaddr;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = w_wdata;
  // Strobe is only meaningful alongside wvalid; keeps it 0 at reset.
  assign m_axi_wstrb   = r_wvalid ? w_wstrb : 8'h00;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule
